stream_mux_rr: RTL and testbench

Parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshakes on every input and on the output, and a registered output stage. It generalises the plain 2:1 select mux into a flow-controlled stream selector with two modes: fixed selection by `sel`, or round-robin arbitration across all valid channels. It sits between several producer streams and a single consumer, and sustains one word per cycle with one cycle of latency.

---
 rtl/stream_mux_rr.sv | 65 ++++++
 tb/tb_stream_mux_rr.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: flow-controlled N:1 stream mux, fixed-select or round-robin,
// with a single registered output stage (one word per cycle, one cycle latency).
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]     in_valid,
    output logic [NCH-1:0]     in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic               rr_en,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_ch
);
    logic [SELW-1:0]  ptr, rr_g, g;
    logic             rr_hit, load_ok, xfer;
    logic [WIDTH-1:0] g_data;

    // Descending scan so the nearest valid channel after ptr is the last to win.
    always_comb begin
        rr_hit = 1'b0;
        rr_g   = '0;
        for (int k = NCH; k >= 1; k--) begin
            if (in_valid[SELW'((int'(ptr) + k) % NCH)]) begin
                rr_hit = 1'b1;
                rr_g   = SELW'((int'(ptr) + k) % NCH);
            end
        end
    end

    assign g       = rr_en ? rr_g : sel;
    assign load_ok = !out_valid || out_ready;
    // An out-of-range sel shifts the one-hot off the top, leaving no grant.
    assign in_ready = (rst_n && load_ok) ?
                      (rr_en ? (rr_hit ? NCH'(1) << rr_g : '0) : NCH'(1) << sel) : '0;
    assign xfer    = |(in_valid & in_ready);

    always_comb begin
        g_data = '0;
        for (int i = 0; i < NCH; i++)
            g_data = g_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{in_ready[i]}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SELW'(NCH - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= g_data;
            out_ch    <= g;
            if (rr_en)
                ptr <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed and random stimulus against a queue/arithmetic reference model.
module tb_stream_mux_rr;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] in_data = '0;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_ready;
    logic [1:0]  sel = '0;
    logic        rr_en = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_ch;

    int checks = 0;
    int errors = 0;

    logic       m_valid;
    logic [7:0] m_data;
    int         m_ch, m_ptr;
    logic [3:0] last_ready, seen;
    logic [7:0] got_q[$];
    logic [7:0] src[$];

    stream_mux_rr #(.WIDTH(8), .NCH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .rr_en(rr_en), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant();
        if (!rr_en)
            return int'(sel);
        for (int k = 1; k <= 4; k++)
            if (in_valid[(m_ptr + k) % 4])
                return (m_ptr + k) % 4;
        return -1;
    endfunction

    // Called just after a falling edge with inputs set; returns just after the next falling edge.
    task automatic cycle();
        int g;
        logic [3:0] er;
        #1;
        g  = model_grant();
        er = (g >= 0 && (!m_valid || out_ready)) ? 4'(1 << g) : 4'b0;
        check("in_ready", in_ready, er);
        last_ready = in_ready;
        if (out_valid && out_ready)
            got_q.push_back(out_data);
        @(posedge clk);
        if (g >= 0 && er[g] && in_valid[g]) begin
            m_valid = 1'b1;
            m_data  = in_data[g*8 +: 8];
            m_ch    = g;
            if (rr_en)
                m_ptr = g;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check("out_data", out_data, m_data);
            check("out_ch", out_ch, m_ch);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = 3;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ch", out_ch, 0);
        check("rst_ready", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset and fixed mode
        rr_en = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 32'h00A5_0000; out_ready = 1'b1;
        #2;
        do_reset();
        cycle();
        check("fix_data", out_data, 8'hA5);
        check("fix_ch", out_ch, 2);
        check("fix_valid", out_valid, 1);
        in_valid = '0;
        cycle();

        // Backpressure on channel 1
        src = '{8'h10, 8'h11, 8'h12};
        got_q.delete();
        sel = 2'd1;
        for (int i = 0; i < 8; i++) begin
            out_ready = (i >= 3);
            in_valid  = (src.size() > 0) ? 4'b0010 : 4'b0000;
            in_data   = (src.size() > 0) ? {16'h0, src[0], 8'h0} : '0;
            cycle();
            if (last_ready[1] && in_valid[1])
                void'(src.pop_front());
            if (i == 1 || i == 2) begin
                check("bp_hold", out_data, 8'h10);
                check("bp_stall_rdy", last_ready, 0);
            end
        end
        check("bp_count", got_q.size(), 3);
        for (int i = 0; i < 3 && i < got_q.size(); i++)
            check("bp_seq", got_q[i], 8'h10 + i);

        // Round-robin fairness with all channels valid
        rr_en = 1'b1; in_valid = 4'b1111; in_data = 32'h0302_0100; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("rr_ch", out_ch, i % 4);
            check("rr_data", out_data, i % 4);
        end
        in_valid = '0;
        cycle();

        // Sparse round-robin: channels 1 and 3
        seen = '0;
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            seen |= last_ready;
            check("sparse_ch", out_ch, (i % 2) ? 3 : 1);
        end
        check("sparse_never", seen & 4'b0101, 0);

        // Fixed select of an idle channel: ready but no load
        rr_en = 1'b0; sel = 2'd3; in_valid = 4'b0111;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("idle_ready", last_ready, 4'b1000);
            check("idle_noload", out_valid, 0);
        end

        // Reset while holding a word; ptr moved to 1 first
        rr_en = 1'b1; in_valid = 4'b0010; in_data = 32'h0000_7700; out_ready = 1'b0;
        cycle();
        check("pre_rst_valid", out_valid, 1);
        do_reset();
        in_valid = 4'b1111; in_data = 32'hDDCC_BBAA; out_ready = 1'b1;
        cycle();
        check("post_rst_ch", out_ch, 0);
        check("post_rst_data", out_data, 8'hAA);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            sel       = 2'($urandom);
            rr_en     = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
